// File: rtl/add_seq_pkg.sv
// Shared constants and state encoding for the nibble-serial add sequencer.
package add_seq_pkg;

  localparam int unsigned NIBBLE = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Nibble index width; a single-nibble datapath still needs one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? 32'($clog2(n)) : 32'd1;
  endfunction

endpackage

// File: rtl/add_seq_fsm.sv
// Control FSM for add_seq_ctrl: state register, nibble index and
// registered ready/busy/done handshake.
module add_seq_fsm
  import add_seq_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = idx_w(N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  output state_e        state_o,
  output logic [IW-1:0] idx_o,
  output logic          accept_c,
  output logic          last_c,
  output logic          ready_o,
  output logic          busy_o,
  output logic          done_o
);

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    accept_c = 1'b0;
    last_c   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          accept_c = 1'b1;
          idx_d    = '0;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        // The index parks at zero after the top nibble instead of wrapping.
        if (idx_q == IW'(N - 1)) begin
          last_c  = 1'b1;
          idx_d   = '0;
          state_d = S_DONE;
        end else begin
          idx_d = idx_q + IW'(1);
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      ready_o <= 1'b1;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      ready_o <= (state_d == S_IDLE);
      busy_o  <= (state_d == S_RUN);
      done_o  <= (state_d == S_DONE);
    end
  end

  assign state_o = state_q;
  assign idx_o   = idx_q;

endmodule

// File: rtl/add_seq_ctrl.sv
// WIDTH-bit adder sequencer time-sharing an external 4-bit add_4, LSB nibble first.
// Optional two's-complement overflow output enabled by ADD_SEQ_OVF_EN.
module add_seq_ctrl
  import add_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
`ifdef ADD_SEQ_OVF_EN
  output logic             ovf,
`endif
  output logic [3:0]       add_0,
  output logic [3:0]       add_1,
  output logic             add_cin,
  input  logic [3:0]       add_out,
  input  logic             add_cout
);

  localparam int unsigned N  = WIDTH / NIBBLE;
  localparam int unsigned IW = idx_w(N);

  state_e        state;
  logic [IW-1:0] idx;
  logic          accept_c, last_c;

  add_seq_fsm #(.N(N), .IW(IW)) u_fsm (
    .clk      (clk),
    .rst      (rst),
    .start_i  (start),
    .state_o  (state),
    .idx_o    (idx),
    .accept_c (accept_c),
    .last_c   (last_c),
    .ready_o  (ready),
    .busy_o   (busy),
    .done_o   (done)
  );

  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [3:0]       add_0_q, add_0_d, add_1_q, add_1_d;
  logic             add_cin_q, add_cin_d, c_out_q, c_out_d;
  logic             ovf_q, ovf_d;

  // Adder pins are registered one cycle ahead: they carry the nibble/carry
  // for the RUN cycle about to start, and zero outside RUN.
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    c_out_d   = c_out_q;
    ovf_d     = ovf_q;
    add_0_d   = '0;
    add_1_d   = '0;
    add_cin_d = 1'b0;
    if (accept_c) begin
      a_d       = a;
      b_d       = b;
      sum_d     = '0;
      c_out_d   = 1'b0;
      ovf_d     = 1'b0;
      add_0_d   = a[NIBBLE-1:0];
      add_1_d   = b[NIBBLE-1:0];
      add_cin_d = c_in;
    end else if (state == S_RUN) begin
      sum_d[NIBBLE*32'(idx) +: NIBBLE] = add_out;
      if (last_c) begin
        c_out_d = add_cout;
        ovf_d   = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (add_out[NIBBLE-1] != a_q[WIDTH-1]);
      end else begin
        add_0_d   = a_q[NIBBLE*(32'(idx) + 32'd1) +: NIBBLE];
        add_1_d   = b_q[NIBBLE*(32'(idx) + 32'd1) +: NIBBLE];
        add_cin_d = add_cout;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      c_out_q   <= 1'b0;
      ovf_q     <= 1'b0;
      add_0_q   <= '0;
      add_1_q   <= '0;
      add_cin_q <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      c_out_q   <= c_out_d;
      ovf_q     <= ovf_d;
      add_0_q   <= add_0_d;
      add_1_q   <= add_1_d;
      add_cin_q <= add_cin_d;
    end
  end

  assign sum     = sum_q;
  assign c_out   = c_out_q;
  assign add_0   = add_0_q;
  assign add_1   = add_1_q;
  assign add_cin = add_cin_q;
`ifdef ADD_SEQ_OVF_EN
  assign ovf     = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Self-checking bench for add_seq_ctrl with a behavioural add_4 and
// arithmetic reference model; covers ADD_SEQ_OVF_EN when defined.
module tb_add_seq_ctrl;

  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk, rst, start, c_in;
  logic [W-1:0] a, b;
  logic         ready, busy, done, c_out;
  logic [W-1:0] sum;
  logic [3:0]   add_0, add_1, add_out;
  logic         add_cin, add_cout;
`ifdef ADD_SEQ_OVF_EN
  logic         ovf;
`endif

  int total = 0;
  int bad   = 0;

  add_seq_ctrl #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (a),
    .b        (b),
    .c_in     (c_in),
    .ready    (ready),
    .busy     (busy),
    .done     (done),
    .sum      (sum),
    .c_out    (c_out),
`ifdef ADD_SEQ_OVF_EN
    .ovf      (ovf),
`endif
    .add_0    (add_0),
    .add_1    (add_1),
    .add_cin  (add_cin),
    .add_out  (add_out),
    .add_cout (add_cout)
  );

  // Stand-in for the external add_4 ripple adder.
  assign {add_cout, add_out} = 5'({1'b0, add_0}) + 5'({1'b0, add_1}) + 5'(add_cin);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; a = 16'h1111; b = 16'h2222; c_in = 1'b1;
    tick(); tick();
    total++;
    if ({ready, busy, done} !== 3'b100) begin
      bad++; $display("FAIL reset_flags: got %b want 100", {ready, busy, done});
    end
    total++;
    if ({c_out, sum} !== 17'h0) begin
      bad++; $display("FAIL reset_sum: got %h want 00000", {c_out, sum});
    end
    total++;
    if ({add_0, add_1, add_cin} !== 9'h0) begin
      bad++; $display("FAIL reset_pins: got %h want 000", {add_0, add_1, add_cin});
    end
    rst = 1'b0; start = 1'b0;
    tick();
    total++;
    if ({ready, busy} !== 2'b10) begin
      bad++; $display("FAIL reset_no_accept: got %b want 10", {ready, busy});
    end
  endtask

  // One full operation, checking every RUN cycle against the arithmetic model.
  // With collide set, start is held high (with junk operands) through RUN and DONE.
  task automatic test_op(input logic [W-1:0] ta, input logic [W-1:0] tb, input logic tc,
                         input bit collide);
    logic [W:0]      full;
    logic [8:0]      exp_pins;
    longint unsigned m, lo;
    full = {1'b0, ta} + {1'b0, tb} + 17'(tc);
    total++;
    if (ready !== 1'b1) begin
      bad++; $display("FAIL op_ready: got %b want 1", ready);
    end
    a = ta; b = tb; c_in = tc; start = 1'b1;
    tick();
    start = collide;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom);
    total++;
    if (sum !== '0) begin
      bad++; $display("FAIL op_sum_clear: got %h want 0000", sum);
    end
    for (int k = 0; k < N; k++) begin
      m  = (64'd1 << (4 * k)) - 64'd1;
      lo = ((64'(ta) & m) + (64'(tb) & m) + 64'(tc)) >> (4 * k);
      exp_pins = {4'(ta >> (4 * k)), 4'(tb >> (4 * k)), lo[0]};
      total++;
      if ({ready, busy, done} !== 3'b010) begin
        bad++; $display("FAIL op_run_flags k=%0d: got %b want 010", k, {ready, busy, done});
      end
      total++;
      if ({add_0, add_1, add_cin} !== exp_pins) begin
        bad++; $display("FAIL op_pins k=%0d: got %h want %h", k, {add_0, add_1, add_cin}, exp_pins);
      end
      tick();
      if (k < N - 1) begin
        m = (64'd1 << (4 * (k + 1))) - 64'd1;
        total++;
        if (sum !== 16'(64'(full) & m)) begin
          bad++; $display("FAIL op_partial k=%0d: got %h want %h", k, sum, 16'(64'(full) & m));
        end
      end
    end
    total++;
    if ({ready, busy, done} !== 3'b001) begin
      bad++; $display("FAIL op_done_flags: got %b want 001", {ready, busy, done});
    end
    total++;
    if ({c_out, sum} !== full) begin
      bad++; $display("FAIL op_result a=%h b=%h c=%b: got %h want %h", ta, tb, tc, {c_out, sum}, full);
    end
`ifdef ADD_SEQ_OVF_EN
    total++;
    if (ovf !== ((ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]))) begin
      bad++; $display("FAIL op_ovf: got %b want %b", ovf, (ta[W-1] == tb[W-1]) && (full[W-1] != ta[W-1]));
    end
`endif
    total++;
    if ({add_0, add_1, add_cin} !== 9'h0) begin
      bad++; $display("FAIL op_done_pins: got %h want 000", {add_0, add_1, add_cin});
    end
    tick();
    start = 1'b0;
    total++;
    if ({ready, busy, done} !== 3'b100) begin
      bad++; $display("FAIL op_idle_flags: got %b want 100", {ready, busy, done});
    end
    total++;
    if ({c_out, sum} !== full) begin
      bad++; $display("FAIL op_hold: got %h want %h", {c_out, sum}, full);
    end
  endtask

  task automatic test_basic();
    test_op(16'h1234, 16'h4321, 1'b0, 1'b0);
  endtask

  task automatic test_carry_chain();
    test_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
  endtask

  task automatic test_busy_collision();
    test_op(16'h0001, 16'h0001, 1'b0, 1'b1);
    tick();
    total++;
    if ({ready, busy, done} !== 3'b100) begin
      bad++; $display("FAIL collide_no_accept: got %b want 100", {ready, busy, done});
    end
  endtask

  task automatic test_mid_reset();
    int seen_done;
    a = 16'h00FF; b = 16'h0001; c_in = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if ({ready, busy, done} !== 3'b100) begin
      bad++; $display("FAIL midrst_flags: got %b want 100", {ready, busy, done});
    end
    total++;
    if ({c_out, sum, add_0, add_1, add_cin} !== 26'h0) begin
      bad++; $display("FAIL midrst_regs: got %h want 0", {c_out, sum, add_0, add_1, add_cin});
    end
    seen_done = 0;
    for (int i = 0; i < N + 2; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen_done++;
    end
    total++;
    if (seen_done != 0) begin
      bad++; $display("FAIL midrst_no_done: got %0d active cycles want 0", seen_done);
    end
  endtask

  task automatic test_overflow();
    test_op(16'h7FFF, 16'h0001, 1'b0, 1'b0);
    test_op(16'h8000, 16'h8000, 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    test_op(16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
    test_op(16'h0000, 16'h0000, 1'b0, 1'b0);
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++) begin
      test_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0;
    test_reset();
    test_basic();
    test_carry_chain();
    test_busy_collision();
    test_mid_reset();
    test_overflow();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/add_seq_ctrl.md
Name: add_seq_ctrl

Overview:
Sequencer that performs a WIDTH-bit addition by time-sharing one external 4-bit ripple adder (add_4), one nibble per cycle, LSB nibble first.
- Drives the adder's operand and carry-in pins and registers its sum/carry-out.
- Presents a start/busy/done handshake to the requester.
- Sits between a host (bench or datapath FSM) and the shared add_4 instance.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of 4 and at least 4.
N (localparam), WIDTH/4, number of nibble cycles per operation.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request pulse; accepted only when ready=1
a  input  WIDTH  operand A; sampled on the accepted start
b  input  WIDTH  operand B; sampled on the accepted start
c_in  input  1  initial carry; sampled on the accepted start
ready  output  1  high in IDLE
busy  output  1  high in RUN
done  output  1  one-cycle pulse; result valid
sum  output  WIDTH  registered result; held until the next accepted start
c_out  output  1  registered final carry; held like sum
add_0  output  4  to add_4.add_0: current A nibble
add_1  output  4  to add_4.add_1: current B nibble
add_cin  output  1  to add_4.c_in: running carry
add_out  input  4  from add_4.out (combinational)
add_cout  input  1  from add_4.c_out (combinational)

Behaviour:
- Reset values: state=IDLE, ready=1, busy=0, done=0, sum=0, c_out=0, add_0=0, add_1=0, add_cin=0, nibble index=0, operand/carry registers=0.
- States:
  - IDLE: start=1 latches a, b, c_in into internal registers; idx<=0; go to RUN. Otherwise stay in IDLE.
  - RUN: add_0=a_reg[4*idx+:4], add_1=b_reg[4*idx+:4], add_cin=carry_reg, all driven from registers. Each cycle: sum[4*idx+:4]<=add_out, carry_reg<=add_cout, idx<=idx+1. When idx==N-1, also c_out<=add_cout and go to DONE.
  - DONE: done=1 for exactly this cycle; go to IDLE. sum and c_out stay stable.
- Latency: start accepted at edge T; RUN occupies N cycles; done is high in cycle T+N+1. For WIDTH=16, done rises 5 cycles after start.
- Throughput: one operation per N+2 cycles. start in DONE is ignored, with no back-to-back acceptance.
- start while busy or in DONE: ignored; latched operands unaffected.
- Operand changes on a/b/c_in after acceptance: no effect.
- Arithmetic: unsigned; {c_out,sum} = a + b + c_in, truncated to WIDTH+1 bits.
- Adder outputs are 0 in IDLE and DONE.
- sum is cleared to 0 on acceptance of a new start, so partial results are visible only as RUN progresses.
- idx uses clog2(N) bits (minimum 1); it never wraps past N-1.
- Reset mid-operation: rst has priority over every transition. Next cycle all registers take reset values and no done is issued.
- rst and start together: reset wins; start is dropped.

Optional Feature:
Macro ADD_SEQ_OVF_EN.
- Defined: adds output port ovf (1 bit), registered with done and held like sum. ovf = (a_reg[MSB]==b_reg[MSB]) && (sum[MSB]!=a_reg[MSB]), i.e. two's-complement overflow. Reset to 0 and cleared on accept.
- Undefined: port and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package add_seq_pkg: state encoding localparams (S_IDLE=2'd0, S_RUN=2'd1, S_DONE=2'd2) and NIBBLE=4.
- The adder stays external (existing add_4), so benches can reuse the proven adder.
- One natural sub-module: add_seq_fsm, holding the state register, idx counter and ready/busy/done decode. Operand/sum registers stay in the top.

Test Plan:
- Reset: rst=1 for 2 cycles with start=1 -> ready=1, busy=0, done=0, sum=0x0000, c_out=0; no acceptance.
- Basic: a=0x1234, b=0x4321, c_in=0, start pulse -> add_0 sequence 4,3,2,1; done 5 cycles later; sum=0x5555, c_out=0.
- Full carry chain: a=0xFFFF, b=0x0000, c_in=1 -> add_cin=1 in every RUN cycle; sum=0x0000, c_out=1.
- Busy collision: start a=0x0001, b=0x0001; re-pulse start with a=0xAAAA, b=0x5555 during RUN and in DONE -> result 0x0002, c_out=0; a single done pulse.
- Mid-op reset: start a=0x00FF, b=0x0001; assert rst in 2nd RUN cycle -> next cycle ready=1, sum=0, c_out=0, adder pins 0; done never asserted.
- Overflow (ADD_SEQ_OVF_EN defined): a=0x7FFF, b=0x0001, c_in=0 -> sum=0x8000, c_out=0, ovf=1. Then a=0x8000, b=0x8000 -> sum=0x0000, c_out=1, ovf=1.
